// File: rtl/mix_columns_seq.sv
// Sequential AES forward MixColumns: transforms COLS_PER_CYCLE columns per clock (1, 2 or 4).
// Defining MIX_COLUMNS_BYPASS_EN adds a bypass input that passes the state through unchanged (final round).
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef MIX_COLUMNS_BYPASS_EN
  input  logic         bypass,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  // state | meaning
  // IDLE  | waiting for a source state, in_ready=1
  // BUSY  | transforming columns in place, one step per clock
  // DONE  | result held on out_data, out_valid=1 until out_ready
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int         STEPS     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  state_t       state_q, state_d;
  logic [1:0]   step_q, step_d;
  logic [127:0] work_q, work_d;
  logic         byp_active;
  int           col;

`ifdef MIX_COLUMNS_BYPASS_EN
  logic byp_q, byp_d;
  assign byp_active = byp_q;
`else
  assign byp_active = 1'b0;
`endif

  function automatic logic [7:0] xt2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt2(a0) ^ xt2(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt2(a1) ^ xt2(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt2(a2) ^ xt2(a3) ^ a3,
            xt2(a0) ^ a0 ^ a1 ^ a2 ^ xt2(a3)};
  endfunction

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    col       = 0;
`ifdef MIX_COLUMNS_BYPASS_EN
    byp_d     = byp_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          step_d  = 2'd0;
          state_d = BUSY;
`ifdef MIX_COLUMNS_BYPASS_EN
          byp_d   = bypass;
`endif
        end
      end
      BUSY: begin
        // Column 0 occupies the MSBs, so ascending columns walk down the word.
        if (!byp_active) begin
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col = int'(step_q) * COLS_PER_CYCLE + k;
            work_d[127 - 32*col -: 32] = mix_col(work_q[127 - 32*col -: 32]);
          end
        end
        step_d = step_q + 2'd1;
        if (step_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      work_q  <= '0;
`ifdef MIX_COLUMNS_BYPASS_EN
      byp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      work_q  <= work_d;
`ifdef MIX_COLUMNS_BYPASS_EN
      byp_q   <= byp_d;
`endif
    end
  end

  assign out_data = work_q;

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYCLE, default 1, setting columns transformed per clock; legal values are 1, 2 and 4.
REQ-002 The block SHALL have port clk, input, 1, the single clock; every state element samples on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning a source state is offered on in_data.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept a state.
REQ-006 The block SHALL have port in_data, input, 128, holding the AES state; column c is bits [127-32c : 96-32c], first byte of each column in the MSBs.
REQ-007 The block SHALL have port out_valid, output, 1, meaning a result is presented on out_data.
REQ-008 The block SHALL have port out_ready, input, 1, meaning the sink accepts the result.
REQ-009 The block SHALL have port out_data, output, 128, holding the forward-MixColumns result in the same column/byte layout as in_data.

Function
REQ-010 The block SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-011 An input transfer SHALL occur when in_valid and in_ready are both 1 on a clock edge.
REQ-012 On an input transfer, the block SHALL load in_data into a 128-bit working register, clear the step counter and move to BUSY.
REQ-013 in_ready SHALL equal 1 only in IDLE.
REQ-014 In BUSY, each clock SHALL transform COLS_PER_CYCLE columns in place, indexed by the step counter, in ascending column order starting at column 0.
REQ-015 Each column SHALL transform bytes a0..a3 as: o0=2a0^3a1^a2^a3, o1=a0^2a1^3a2^a3, o2=a0^a1^2a2^3a3, o3=3a0^a1^a2^2a3, all in GF(2^8) modulo x^8+x^4+x^3+x+1.
REQ-016 Multiplication by 2 SHALL be a left shift by 1 XOR 8'h1b when the source MSB is 1; multiplication by 3 SHALL be the x2 result XOR the source byte.
REQ-017 After the step that processes column 3, the block SHALL enter DONE, with out_valid=1 on the following cycle.
REQ-018 Latency SHALL be 4/COLS_PER_CYCLE clock edges from the input-transfer edge to the first cycle in which out_valid=1.
REQ-019 out_valid SHALL equal 1 only in DONE.
REQ-020 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-021 On an edge where out_valid and out_ready are both 1, the block SHALL return to IDLE; the block SHALL NOT accept a new input on that same edge.
REQ-022 The block SHALL drive out_data from the working register; its value outside DONE is don't-care except after reset.
REQ-023 in_data and in_valid SHALL be ignored in BUSY and DONE.

Reset
REQ-024 While rst=1 at an edge, the block SHALL set state=IDLE, step counter=0, working register=0, in_ready=1 (from the next cycle), out_valid=0 and out_data=0.
REQ-025 rst SHALL override every other event, including a reset asserted mid-BUSY or mid-DONE; any partial result SHALL be discarded.

Configuration
REQ-026 With macro MIX_COLUMNS_BYPASS_EN defined, the block SHALL add port bypass, input, 1, sampled on the input-transfer edge.
REQ-027 With MIX_COLUMNS_BYPASS_EN defined and bypass sampled as 1, columns SHALL pass through unchanged; latency and handshake SHALL be identical to the non-bypass case (final AES round).
REQ-028 Without MIX_COLUMNS_BYPASS_EN, the bypass port SHALL be absent and every state SHALL be transformed.

Verification
REQ-029 The bench SHALL drive in_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5 with COLS_PER_CYCLE=1, and SHALL check out_data=046681e5_e0cb199a_48f8d37a_2806264c with out_valid first high 4 edges after accept.
REQ-030 The bench SHALL drive in_data=db135345_f20a225c_01010101_c6c6c6c6, and SHALL check out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with latency 1 for COLS_PER_CYCLE=4 and 2 for COLS_PER_CYCLE=2.
REQ-031 The bench SHALL hold out_ready=0 for 10 cycles after out_valid rises, and SHALL check that out_data is stable and in_ready=0 with in_valid=1 during that time; on the out_ready=1 edge the block SHALL return to IDLE with in_ready=1 on the next cycle.
REQ-032 The bench SHALL assert rst for 1 cycle two edges after accept, and SHALL check out_valid=0, out_data=0 and in_ready=1 next cycle; a following vector SHALL produce the correct result.
REQ-033 With MIX_COLUMNS_BYPASS_EN defined, the bench SHALL drive bypass=1 with the REQ-029 input, and SHALL check that out_data equals in_data with the same latency; bypass=0 SHALL give the REQ-029 output.
